// File: rtl/vga_pixel_output_if.sv
// Signal bundle between the colour/timing logic (master) and the VGA output stage (slave).
// Colours are packed {Blue[8:6], Green[5:3], Red[2:0]}; all syncs are active-low.
interface vga_pixel_output_if;
  logic [8:0] charRGB;
  logic [8:0] bgRGB;
  logic       pixelOn;
  logic       videoOn;
  logic       hsyncIn;
  logic       vsyncIn;
  logic       blinkEn;
  logic [2:0] red;
  logic [2:0] green;
  logic [2:0] blue;
  logic       hsync;
  logic       vsync;
  logic       frameTick;

  // There is no handshake: the stage accepts one pixel every clock and cannot stall.
  modport master (
    output charRGB, bgRGB, pixelOn, videoOn, hsyncIn, vsyncIn, blinkEn,
    input  red, green, blue, hsync, vsync, frameTick
  );

  modport slave (
    input  charRGB, bgRGB, pixelOn, videoOn, hsyncIn, vsyncIn, blinkEn,
    output red, green, blue, hsync, vsync, frameTick
  );
endinterface

// File: rtl/vga_pixel_output.sv
// VGA output stage: two-cycle pixel/sync pipeline with colours latched only at frame start
// (vsync falling edge) and a frame-counted blink that swaps glyph pixels to background.
module vga_pixel_output #(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input logic               clk,
  input logic               reset,
  vga_pixel_output_if.slave bus
);
  localparam logic [7:0] LP_CNT_LAST = 8'(BLINK_FRAMES - 1);

  logic       r_vsync_prev;
  logic [8:0] r_char_shadow;
  logic [8:0] r_bg_shadow;
  logic [7:0] r_frame_cnt;
  logic       r_blink_phase;
  logic       r_frame_tick;

  logic       r_s1_pixel;
  logic       r_s1_video;
  logic       r_s1_hsync;
  logic       r_s1_vsync;

  logic [8:0] r_colour;
  logic       r_hsync;
  logic       r_vsync;

  logic       w_latch;
  logic       w_fg;
  logic [8:0] w_colour;

  // r_vsync_prev resets high so a vsync already low after reset still counts as a frame start.
  assign w_latch  = ~bus.vsyncIn & r_vsync_prev;
  assign w_fg     = r_s1_pixel & ~(bus.blinkEn & r_blink_phase);
  assign w_colour = r_s1_video ? (w_fg ? r_char_shadow : r_bg_shadow) : 9'h000;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vsync_prev  <= 1'b1;
      r_char_shadow <= 9'h1FF;
      r_bg_shadow   <= 9'h000;
      r_frame_cnt   <= 8'd0;
      r_blink_phase <= 1'b0;
      r_frame_tick  <= 1'b0;
    end else begin
      r_vsync_prev <= bus.vsyncIn;
      r_frame_tick <= w_latch;
      if (w_latch) begin
        r_char_shadow <= bus.charRGB;
        r_bg_shadow   <= bus.bgRGB;
        if (r_frame_cnt == LP_CNT_LAST) begin
          r_frame_cnt   <= 8'd0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_pixel <= 1'b0;
      r_s1_video <= 1'b0;
      r_s1_hsync <= 1'b1;
      r_s1_vsync <= 1'b1;
      r_colour   <= 9'h000;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
    end else begin
      r_s1_pixel <= bus.pixelOn;
      r_s1_video <= bus.videoOn;
      r_s1_hsync <= bus.hsyncIn;
      r_s1_vsync <= bus.vsyncIn;
      r_colour   <= w_colour;
      r_hsync    <= r_s1_hsync;
      r_vsync    <= r_s1_vsync;
    end
  end

  assign bus.red       = r_colour[2:0];
  assign bus.green     = r_colour[5:3];
  assign bus.blue      = r_colour[8:6];
  assign bus.hsync     = r_hsync;
  assign bus.vsync     = r_vsync;
  assign bus.frameTick = r_frame_tick;
endmodule
